// File: rtl/eth_mii_rx_framer.sv
// MII receive framer: strips preamble/SFD, assembles bytes low nibble first,
// writes them to the receive buffer and holds per-frame status until acked.
module eth_mii_rx_framer #(
    parameter int BUF_ADDR_W = 11,
    parameter int MIN_LEN    = 64,
    parameter int MAX_LEN    = 1518
) (
    input  logic                  RX_CLK,
    input  logic                  RESETN,
    input  logic [3:0]            RX_DATA,
    input  logic                  RX_DV,
    output logic                  buf_wen,
    output logic [BUF_ADDR_W-1:0] buf_addr,
    output logic [7:0]            buf_wdata,
    input  logic                  rx_ack,
    output logic                  frame_ready,
    output logic [10:0]           frame_len,
    output logic                  err_crc,
    output logic                  err_short,
    output logic                  err_long,
    output logic                  err_align,
    output logic [7:0]            drop_cnt
);
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] LEN_MAX     = 11'(MAX_LEN);
    localparam logic [10:0] LEN_SAT     = 11'(MAX_LEN + 1);
    localparam logic [10:0] LEN_MIN     = 11'(MIN_LEN);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_SKIP, S_END} state_t;

    // Reflected CRC-32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    logic [3:0]  rxd_q;
    logic        rxdv_q;
    state_t      state;
    logic        phase;
    logic [3:0]  lo_nib;
    logic [10:0] cnt;
    logic [31:0] crc;
    logic        long_q;
    logic [7:0]  cur_byte;

    assign cur_byte = {rxd_q, lo_nib};

    always_ff @(posedge RX_CLK or negedge RESETN) begin
        if (!RESETN) begin
            rxd_q       <= '0;
            rxdv_q      <= 1'b0;
            state       <= S_IDLE;
            phase       <= 1'b0;
            lo_nib      <= '0;
            cnt         <= '0;
            crc         <= '1;
            long_q      <= 1'b0;
            buf_wen     <= 1'b0;
            buf_addr    <= '0;
            buf_wdata   <= '0;
            frame_ready <= 1'b0;
            frame_len   <= '0;
            err_crc     <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            err_align   <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            rxd_q   <= RX_DATA;
            rxdv_q  <= RX_DV;
            buf_wen <= 1'b0;

            if (frame_ready && rx_ack) begin
                frame_ready <= 1'b0;
                frame_len   <= '0;
                err_crc     <= 1'b0;
                err_short   <= 1'b0;
                err_long    <= 1'b0;
                err_align   <= 1'b0;
            end

            case (state)
                S_IDLE: if (rxdv_q) state <= (rxd_q == 4'h5) ? S_PRE : S_SKIP;

                S_PRE: begin
                    if (!rxdv_q)
                        state <= S_IDLE;
                    else if (rxd_q == 4'hD) begin
                        // Status still pending: the whole frame is discarded.
                        if (frame_ready) begin
                            state <= S_SKIP;
                            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                        end else begin
                            state  <= S_DATA;
                            phase  <= 1'b0;
                            cnt    <= '0;
                            crc    <= '1;
                            long_q <= 1'b0;
                        end
                    end else if (rxd_q != 4'h5)
                        state <= S_SKIP;
                end

                S_DATA: begin
                    if (!rxdv_q)
                        state <= S_END;
                    else if (!phase) begin
                        lo_nib <= rxd_q;
                        phase  <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        crc   <= crc32_byte(crc, cur_byte);
                        if (cnt < LEN_MAX) begin
                            buf_wen   <= 1'b1;
                            buf_addr  <= BUF_ADDR_W'(cnt);
                            buf_wdata <= cur_byte;
                        end
                        if (cnt == LEN_MAX) long_q <= 1'b1;
                        if (cnt != LEN_SAT) cnt <= cnt + 11'd1;
                    end
                end

                S_SKIP: if (!rxdv_q) state <= S_IDLE;

                // Placed after the ack clear so a same-cycle ack loses to the set.
                S_END: begin
                    state       <= S_IDLE;
                    frame_ready <= 1'b1;
                    frame_len   <= cnt;
                    err_crc     <= (crc != CRC_RESIDUE);
                    err_short   <= (cnt < LEN_MIN);
                    err_long    <= long_q;
                    err_align   <= phase;
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_mii_rx_framer.sv
// Directed bench for eth_mii_rx_framer: frame-level model predicts buffer
// writes and status; a negedge monitor compares them every cycle.
module tb_eth_mii_rx_framer;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
    localparam int AW      = 11;

    logic          RX_CLK = 1'b0;
    logic          RESETN = 1'b1;
    logic [3:0]    RX_DATA = '0;
    logic          RX_DV = 1'b0;
    logic          rx_ack = 1'b0;
    logic          buf_wen;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_wdata;
    logic          frame_ready;
    logic [10:0]   frame_len;
    logic          err_crc, err_short, err_long, err_align;
    logic [7:0]    drop_cnt;

    eth_mii_rx_framer #(.BUF_ADDR_W(AW), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .RX_CLK(RX_CLK), .RESETN(RESETN), .RX_DATA(RX_DATA), .RX_DV(RX_DV),
        .buf_wen(buf_wen), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .rx_ack(rx_ack), .frame_ready(frame_ready), .frame_len(frame_len),
        .err_crc(err_crc), .err_short(err_short), .err_long(err_long),
        .err_align(err_align), .drop_cnt(drop_cnt)
    );

    always #5 RX_CLK = ~RX_CLK;

    typedef struct {
        int len;
        bit crc, sh, lg, al;
    } st_t;

    int         total = 0;
    int         bad = 0;
    logic [18:0] exp_wr[$];
    st_t         exp_st[$];
    logic [7:0]  frm[$];
    int          nib_idx = 0;
    int          ack_at = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Standard Ethernet CRC-32 (final inversion applied) over the first n bytes.
    function automatic logic [31:0] crc_of(input logic [7:0] q[$], input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++)
                c = ((c[0] ^ q[i][b]) != 1'b0) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return ~c;
    endfunction

    task automatic mk_frame(input int ndata);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < ndata; i++) frm.push_back(8'(i));
        c = crc_of(frm, ndata);
        for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
    endtask

    // Frame-level expectation: which bytes land in the buffer and what status follows.
    task automatic expect_frame(input bit extra);
        int          n;
        logic [31:0] c;
        st_t         s;
        n = frm.size();
        for (int i = 0; i < n && i < MAX_LEN; i++) exp_wr.push_back({11'(i), frm[i]});
        s.len = (n > MAX_LEN) ? MAX_LEN + 1 : n;
        s.lg  = (n > MAX_LEN);
        s.sh  = (s.len < MIN_LEN);
        s.al  = extra;
        c     = crc_of(frm, n - 4);
        s.crc = !(frm[n-4] == c[7:0] && frm[n-3] == c[15:8] &&
                  frm[n-2] == c[23:16] && frm[n-1] == c[31:24]);
        exp_st.push_back(s);
    endtask

    task automatic nib(input logic [3:0] d, input logic dv);
        RX_DATA = d;
        RX_DV   = dv;
        rx_ack  = (ack_at >= 0 && nib_idx == ack_at);
        nib_idx++;
        @(posedge RX_CLK);
        #1;
        rx_ack = 1'b0;
    endtask

    task automatic preamble();
        nib_idx = 0;
        for (int i = 0; i < 15; i++) nib(4'h5, 1'b1);
        nib(4'hD, 1'b1);
    endtask

    task automatic send(input bit extra);
        preamble();
        foreach (frm[i]) begin
            nib(frm[i][3:0], 1'b1);
            nib(frm[i][7:4], 1'b1);
        end
        if (extra) nib(4'hA, 1'b1);
        nib(4'h0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) nib(4'h0, 1'b0);
    endtask

    // frame_ready must rise exactly two edges after the registered DV=0.
    task automatic ready_timing(input string name);
        chk({name, "_rdy_e0"}, frame_ready, 0);
        idle(1);
        chk({name, "_rdy_e1"}, frame_ready, 0);
        idle(1);
        chk({name, "_rdy_e2"}, frame_ready, 1);
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        @(posedge RX_CLK);
        #1;
        rx_ack = 1'b0;
        chk("ack_clears", frame_ready, 0);
    endtask

    logic [18:0] e_wr;
    st_t         e_st, cap;
    logic        prev_fr = 1'b0;

    always @(negedge RX_CLK) begin
        if (buf_wen) begin
            if (exp_wr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_write: got addr=%0d data=0x%0h expected no write", buf_addr, buf_wdata);
            end else begin
                e_wr = exp_wr.pop_front();
                chk("wr_addr", 32'(buf_addr), 32'(e_wr[18:8]));
                chk("wr_data", 32'(buf_wdata), 32'(e_wr[7:0]));
            end
        end
        if (frame_ready && !prev_fr) begin
            if (exp_st.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_status: got frame_ready=1 expected 0");
            end else begin
                e_st = exp_st.pop_front();
                chk("st_len", 32'(frame_len), e_st.len);
                chk("st_crc", 32'(err_crc), 32'(e_st.crc));
                chk("st_short", 32'(err_short), 32'(e_st.sh));
                chk("st_long", 32'(err_long), 32'(e_st.lg));
                chk("st_align", 32'(err_align), 32'(e_st.al));
                cap = e_st;
            end
        end else if (frame_ready) begin
            chk("st_stable", {err_crc, err_short, err_long, err_align, 17'(frame_len)},
                {cap.crc, cap.sh, cap.lg, cap.al, 17'(cap.len)});
        end else begin
            chk("st_cleared", {err_crc, err_short, err_long, err_align, 17'(frame_len)}, 0);
        end
        prev_fr = frame_ready;
    end

    initial begin
        logic [7:0] pin[$];
        #2 RESETN = 1'b0;
        repeat (3) @(posedge RX_CLK);
        #1;
        chk("rst_outputs", {buf_wen, 11'(buf_addr), buf_wdata, frame_ready, frame_len,
                            err_crc, err_short, err_long, err_align, drop_cnt}, 0);
        RESETN = 1'b1;
        idle(2);

        // Model pins: CRC-32 check value and FCS-appended frame size.
        pin = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("pin_crc_check", crc_of(pin, 9), 32'hCBF43926);
        mk_frame(60);
        chk("pin_frame_size", frm.size(), 64);

        // Good 64-byte frame
        expect_frame(0); send(0); ready_timing("A");
        chk("A_len", frame_len, 64); chk("A_crc", err_crc, 0); chk("A_short", err_short, 0);
        do_ack(); idle(2);

        // Corrupted FCS
        mk_frame(60); frm[63] = frm[63] ^ 8'h01;
        expect_frame(0); send(0); ready_timing("B");
        chk("B_crc", err_crc, 1); chk("B_len", frame_len, 64);
        do_ack(); idle(2);

        // Short frame, valid FCS
        mk_frame(36);
        expect_frame(0); send(0); ready_timing("C");
        chk("C_short", err_short, 1); chk("C_crc", err_crc, 0); chk("C_len", frame_len, 40);
        do_ack(); idle(2);

        // Oversize frame: 1518 writes, length saturates
        mk_frame(1596);
        expect_frame(0); send(0); ready_timing("D");
        chk("D_len", frame_len, 1519); chk("D_long", err_long, 1);
        do_ack(); idle(2);

        // Dangling nibble
        mk_frame(60);
        expect_frame(1); send(1); ready_timing("E");
        chk("E_align", err_align, 1); chk("E_crc", err_crc, 0); chk("E_len", frame_len, 64);

        // Second frame while status pending is dropped
        mk_frame(36); send(0); idle(4);
        chk("F_drop", drop_cnt, 1); chk("F_keep_len", frame_len, 64); chk("F_keep_align", err_align, 1);
        do_ack(); idle(2);

        // Accepted normally after ack
        mk_frame(60);
        expect_frame(0); send(0); ready_timing("G");
        do_ack(); idle(2);

        // Back-to-back with a single DV=0 gap; ack lands during the second preamble
        mk_frame(60); expect_frame(0); send(0);
        mk_frame(36); expect_frame(0);
        ack_at = 6; send(0); ack_at = -1;
        ready_timing("I");
        chk("I_short", err_short, 1); chk("I_drop", drop_cnt, 1);
        do_ack(); idle(2);

        // Reset in mid-frame: bytes 0..29 written, nothing afterwards
        mk_frame(60);
        for (int i = 0; i < 30; i++) exp_wr.push_back({11'(i), frm[i]});
        preamble();
        for (int i = 0; i < 31; i++) begin
            nib(frm[i][3:0], 1'b1);
            nib(frm[i][7:4], 1'b1);
        end
        RESETN = 1'b0;
        #1;
        chk("R_rst_outputs", {buf_wen, frame_ready, frame_len, drop_cnt}, 0);
        chk("R_wr_drained", exp_wr.size(), 0);
        nib(frm[31][3:0], 1'b1);
        nib(frm[31][7:4], 1'b1);
        RESETN = 1'b1;
        for (int i = 32; i < 64; i++) begin
            nib(frm[i][3:0], 1'b1);
            nib(frm[i][7:4], 1'b1);
        end
        idle(5);
        chk("R_no_ready", frame_ready, 0);

        // Next full frame received from address 0
        mk_frame(60);
        expect_frame(0); send(0); ready_timing("J");
        chk("J_len", frame_len, 64); chk("J_crc", err_crc, 0);
        do_ack(); idle(3);

        chk("end_wr_queue", exp_wr.size(), 0);
        chk("end_st_queue", exp_st.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
